// File: rtl/bcrypt_pkg.sv
// Shared definitions for the bcrypt key-schedule expansion logic.
//   - FSM state type of the ExpandState sequencer
//   - SRAM address width and P-array / S-box placement
//   - encryption counts (P-array pairs, S-box pairs, total)
package bcrypt_pkg;

  localparam int ADDR_W = 12;

  localparam logic [ADDR_W-1:0] P_ARRAY_OFFSET = 12'd4000;
  localparam logic [ADDR_W-1:0] S_BASE         = 12'd0;

  localparam int N_P_PAIRS = 9;
  localparam int N_S_PAIRS = 512;
  localparam int TOTAL_ENC = N_P_PAIRS + N_S_PAIRS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MIX,
    ST_LAUNCH,
    ST_WAIT_F,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/expand_state_ctrl_salt_mixer.sv
// salt_mixer: combinational salt word select and XOR for one block.
//   en     : 1 = XOR salt words into the block, 0 = pass through
//   odd    : selects W2/W3 (odd encryption index) instead of W0/W1
//   salt   : W0=[127:96], W1=[95:64], W2=[63:32], W3=[31:0]
//   l_in/r_in   : running block
//   l_out/r_out : block presented to the feistel stage
module salt_mixer (
  input  logic         en,
  input  logic         odd,
  input  logic [127:0] salt,
  input  logic [31:0]  l_in,
  input  logic [31:0]  r_in,
  output logic [31:0]  l_out,
  output logic [31:0]  r_out
);

  logic [31:0] w_l;
  logic [31:0] w_r;

  assign w_l   = odd ? salt[63:32] : salt[127:96];
  assign w_r   = odd ? salt[31:0]  : salt[95:64];
  assign l_out = en ? (l_in ^ w_l) : l_in;
  assign r_out = en ? (r_in ^ w_r) : r_in;

endmodule

// File: rtl/expand_state_ctrl.sv
// expand_state_ctrl: sequencer for bcrypt ExpandState / Expand0State.
// Runs 521 chained block encryptions through an external feistel stage and
// writes each result pair into the shared P-array / S-box SRAM.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin expansion (honoured only in IDLE)
//   use_salt, salt        : salt control/words, latched on start
//   busy, done            : run in progress / one-cycle completion pulse
//   fe_start, fe_L, fe_R  : launch pulse and plaintext to the feistel stage
//   fe_resultL/R, fe_done : feistel result and completion pulse
//   mem_own               : this block owns the SRAM ports (WRITE only)
//   addr_*, data_out_*    : SRAM write address/data, ports a and b
//   cs_*_l, we_*_l, oe_*_l: active-low SRAM strobes
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; latches salt, clears block and index
// MIX      | optional salt XOR, register plaintext into fe_L/fe_R
// LAUNCH   | one-cycle fe_start pulse
// WAIT_F   | hold plaintext, capture result on fe_done
// WRITE    | drive SRAM write of the result pair
// NEXT     | advance index or finish after the last encryption
// DONE     | one-cycle done pulse
module expand_state_ctrl
  import bcrypt_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         use_salt,
  input  logic [127:0] salt,
  output logic         busy,
  output logic         done,
  output logic         fe_start,
  output logic [31:0]  fe_L,
  output logic [31:0]  fe_R,
  input  logic [31:0]  fe_resultL,
  input  logic [31:0]  fe_resultR,
  input  logic         fe_done,
  output logic         mem_own,
  output logic [11:0]  addr_a,
  output logic [11:0]  addr_b,
  output logic [31:0]  data_out_a,
  output logic [31:0]  data_out_b,
  output logic         cs_a_l,
  output logic         we_a_l,
  output logic         oe_a_l,
  output logic         cs_b_l,
  output logic         we_b_l,
  output logic         oe_b_l
);

  localparam logic [9:0] N_P_IDX  = 10'(N_P_PAIRS);
  localparam logic [9:0] LAST_IDX = 10'(TOTAL_ENC - 1);

  state_t       state_q, state_d;
  logic [9:0]   n_q, n_d;
  logic [31:0]  l_q, l_d;
  logic [31:0]  r_q, r_d;
  logic [31:0]  fe_l_q, fe_l_d;
  logic [31:0]  fe_r_q, fe_r_d;
  logic         use_salt_q, use_salt_d;
  logic [127:0] salt_q, salt_d;

  logic [31:0]        mix_l, mix_r;
  logic [9:0]         n_s;
  logic [ADDR_W-1:0]  wr_addr;
  logic               in_write;

  salt_mixer u_mixer (
    .en    (use_salt_q),
    .odd   (n_q[0]),
    .salt  (salt_q),
    .l_in  (l_q),
    .r_in  (r_q),
    .l_out (mix_l),
    .r_out (mix_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      l_q        <= '0;
      r_q        <= '0;
      fe_l_q     <= '0;
      fe_r_q     <= '0;
      use_salt_q <= 1'b0;
      salt_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      l_q        <= l_d;
      r_q        <= r_d;
      fe_l_q     <= fe_l_d;
      fe_r_q     <= fe_r_d;
      use_salt_q <= use_salt_d;
      salt_q     <= salt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    l_d        = l_q;
    r_d        = r_q;
    fe_l_d     = fe_l_q;
    fe_r_d     = fe_r_q;
    use_salt_d = use_salt_q;
    salt_d     = salt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          use_salt_d = use_salt;
          salt_d     = salt;
          l_d        = '0;
          r_d        = '0;
          n_d        = '0;
          state_d    = ST_MIX;
        end
      end
      ST_MIX: begin
        l_d     = mix_l;
        r_d     = mix_r;
        fe_l_d  = mix_l;
        fe_r_d  = mix_r;
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_WAIT_F;
      ST_WAIT_F: begin
        if (fe_done) begin
          // the result becomes the chained block for the next encryption
          l_d     = fe_resultL;
          r_d     = fe_resultR;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_NEXT;
      ST_NEXT: begin
        if (n_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          n_d     = n_q + 10'd1;
          state_d = ST_MIX;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // pair index scaled by two; S-box region index counts from the first S write
  assign n_s     = n_q - N_P_IDX;
  assign wr_addr = (n_q < N_P_IDX) ? (P_ARRAY_OFFSET + {1'b0, n_q, 1'b0})
                                   : (S_BASE + {1'b0, n_s, 1'b0});
  assign in_write = (state_q == ST_WRITE);

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign fe_start   = (state_q == ST_LAUNCH);
  assign fe_L       = fe_l_q;
  assign fe_R       = fe_r_q;
  assign mem_own    = in_write;
  assign addr_a     = in_write ? wr_addr : '0;
  assign addr_b     = in_write ? (wr_addr + 12'd1) : '0;
  assign data_out_a = in_write ? l_q : '0;
  assign data_out_b = in_write ? r_q : '0;
  assign cs_a_l     = ~in_write;
  assign we_a_l     = ~in_write;
  assign oe_a_l     = 1'b1;
  assign cs_b_l     = ~in_write;
  assign we_b_l     = ~in_write;
  assign oe_b_l     = 1'b1;

endmodule
